// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the serial-to-parallel collector.
package demux_pkg;

  localparam int WORD_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  function automatic int addr_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/demultiplexer_collector_bit_index_counter.sv
// Bit position counter: clears on frame start, steps on each accepted bit and
// wraps after WIDTH-1. A clear and an increment together land on index 1.
module bit_index_counter
  import demux_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = addr_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] idx,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH - 1);

  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W-1:0] base_idx;
  logic [ADDR_W-1:0] idx_next;

  always_comb begin
    base_idx = clr ? '0 : idx_reg;
    idx_next = base_idx;
    if (inc) begin
      idx_next = (base_idx == LAST_IDX) ? '0 : base_idx + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
    end else begin
      idx_reg <= idx_next;
    end
  end

  assign idx  = idx_reg;
  assign last = (idx_reg == LAST_IDX);

endmodule

// File: rtl/demultiplexer_collector.sv
// Collects one serial bit per handshake into a word (LSB first) and presents
// each completed word on a valid/ready port; bit_addr can drive an upstream mux.
module demultiplexer_collector
  import demux_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = addr_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [ADDR_W-1:0] bit_addr,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sync_err
);

  logic [ADDR_W-1:0] bit_idx;
  logic              idx_last;
  logic [ADDR_W-1:0] eff_idx;
  logic              eff_last;
  logic              acc;
  logic              word_done;
  logic [WIDTH-1:0]  bit_we;
  logic [WIDTH-1:0]  coll_reg;
  logic [WIDTH-1:0]  word_next;
  logic [WIDTH-1:0]  out_data_reg;
  logic              out_valid_reg;
  logic              sync_err_reg;

  bit_index_counter #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .inc  (acc),
    .clr  (in_sof),
    .idx  (bit_idx),
    .last (idx_last)
  );

  // A frame start forces the current bit to position 0.
  assign eff_idx   = in_sof ? '0 : bit_idx;
  assign eff_last  = !in_sof && idx_last;

  // Only the completing bit can stall, and only while the last word is unread.
  assign in_ready  = !(eff_last && out_valid_reg && !out_ready);
  assign acc       = in_valid && in_ready;
  assign word_done = acc && eff_last;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_we
      assign bit_we[gi] = acc && (eff_idx == ADDR_W'(gi));
    end
  endgenerate

  assign word_next = {in_bit, coll_reg[WIDTH-2:0]};

  // Positions are not cleared between words; every word rewrites all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_reg <= '0;
    end else begin
      coll_reg <= (coll_reg & ~bit_we) | ({WIDTH{in_bit}} & bit_we);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      if (word_done) begin
        out_data_reg  <= word_next;
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
      sync_err_reg <= in_sof && (bit_idx != '0);
    end
  end

  assign bit_addr  = bit_idx;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign sync_err  = sync_err_reg;

endmodule

// File: doc/demultiplexer_collector.md
Name: demultiplexer_collector

Overview:
- Sequential counterpart of the team's 8:1 bit multiplexer.
- Accepts one serial bit per handshake and writes it into position data[bit_addr] of a collection register.
- After WIDTH bits, presents the assembled word on a valid/ready output port.
- bit_addr is exported so the same counter can drive the address input of an upstream multiplexer, giving a loop-back path: parallel to serial to parallel.

Parameters:
- WIDTH, 8, word width in bits; legal values are 2 and above.
- ADDR_W, $clog2(WIDTH), width of the bit index.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_sof  input  1  start of frame: the current bit, or the next accepted bit, is index 0.
- in_ready  output  1  the block accepts in_bit this cycle.
- bit_addr  output  ADDR_W  index that the next accepted bit is written to.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  downstream consumes out_data.
- sync_err  output  1  one-cycle pulse when a partial word is discarded by in_sof.

Behaviour:
- Reset (rst=1 at a clock edge):
  - bit_idx=0, coll_reg=0, out_data=0, out_valid=0, sync_err=0.
  - rst overrides every other input in that cycle, including mid-word; the partial word is lost and no sync_err is raised.
- Effective index:
  - eff_idx = in_sof ? 0 : bit_idx.
  - bit_addr = bit_idx (registered value, not eff_idx).
- Ready:
  - in_ready = !(eff_idx==WIDTH-1 && out_valid && !out_ready).
  - Only the completing bit can stall; bits 0..WIDTH-2 are always accepted.
  - in_ready is combinational from in_sof, out_valid and out_ready only; it never depends on in_valid.
- Accept (acc) = in_valid && in_ready.
- On acc:
  - coll_reg[eff_idx] <= in_bit.
  - If eff_idx==WIDTH-1: out_data <= coll_reg with bit WIDTH-1 replaced by in_bit; out_valid <= 1; bit_idx <= 0 (wrap).
  - Otherwise: bit_idx <= eff_idx+1.
- Frame alignment with no accepted bit: in_sof=1 while acc=0 sets bit_idx <= 0.
- Stale bits: coll_reg bits are not cleared when a word completes. Each word overwrites every position before it is emitted.
- sync_err:
  - Registered; 1 in the cycle after in_sof=1 arrives while bit_idx!=0.
  - This holds whether or not a bit is accepted in that cycle. Otherwise sync_err=0.
- Output handshake:
  - out_valid falls when out_valid && out_ready, unless a new word completes in the same cycle; in that case out_valid stays 1 and out_data takes the new word.
  - out_data is held stable while out_valid && !out_ready.
- Latency and throughput:
  - The completing bit is accepted at edge N; out_valid=1 and the word are visible after edge N.
  - Sustained throughput is 1 word per WIDTH accepted bits, with zero bubbles when out_ready=1.
- in_valid=0 cycles: no state change except the in_sof clear described above.
- Bit order: bit index 0 is the first bit after a frame start (LSB first), matching the multiplexer's address 0 to WIDTH-1 sweep.

Decomposition:
- Shared package demux_pkg:
  - WORD_W constant = 8.
  - Function addr_w(width) returning $clog2(width).
  - Typedef word_t = logic [WORD_W-1:0].
- One natural sub-module: bit_index_counter (clk, rst, inc, clr, wrap at WIDTH-1, outputs idx and last). The top level keeps coll_reg, the output register and the handshake.

Test Plan:
- Reset, then stream bits 1,0,1,1,0,0,1,0 (in_sof=1 on the first) with out_ready=1 -> one cycle after the 8th accept: out_valid=1, out_data=8'h4D; bit_addr steps 0..7 and back to 0.
- Two back-to-back words 8'hA5 then 8'h3C, in_valid=1 continuously, out_ready=1 -> in_ready never drops; out_valid pulses exactly once per word, 8 cycles apart, with the correct data.
- out_ready=0 after word 8'hFF, next word 8'h01 streamed -> bits 0..6 accepted; in_ready=0 at bit_addr=7 until out_ready=1. At that edge 8'hFF is consumed and the final bit is accepted; next cycle out_data=8'h01 and out_valid=1.
- After 3 bits, assert in_sof with in_valid and stream 8'h96 -> sync_err=1 for exactly one cycle; the output word is 8'h96 with no residue from the discarded partial.
- Assert rst after 5 bits, then send a full word 8'h5A -> outputs are 0 after reset; the first word out is 8'h5A; sync_err stays 0.
- Drive in_valid=0 gaps of random length between bits of 8'hC3 -> out_data=8'hC3; bit_addr holds its value during gaps.
